// File: rtl/istr_pkg.sv
// Shared constants, types and the field-to-word encoder for the instruction-stream writer.
// The optional NOP padding feature is enabled by defining ISTR_NOP_PAD_EN.
package istr_pkg;

    localparam int unsigned OP_W       = 6;
    localparam int unsigned FUNC_W     = 6;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned IMM16_W    = 16;
    localparam int unsigned IMM26_W    = 26;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned CNT_W      = 11;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        FMT_R       = 2'd0,
        FMT_I       = 2'd1,
        FMT_J       = 2'd2,
        FMT_SYSCALL = 2'd3
    } fmt_e;

    localparam logic [WORD_W-1:0] SYSCALL_WORD = 32'h0000_000C;
    localparam logic [WORD_W-1:0] NOP_WORD     = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic logic [WORD_W-1:0] encode(
        input logic [1:0]         fmt,
        input logic [OP_W-1:0]    op,
        input logic [REG_W-1:0]   rs,
        input logic [REG_W-1:0]   rt,
        input logic [REG_W-1:0]   rd,
        input logic [REG_W-1:0]   shamt,
        input logic [FUNC_W-1:0]  func,
        input logic [IMM16_W-1:0] imm16,
        input logic [IMM26_W-1:0] imm26
    );
        logic [WORD_W-1:0] word;
        unique case (fmt_e'(fmt))
            FMT_R:   word = {op, rs, rt, rd, shamt, func};
            FMT_I:   word = {op, rs, rt, imm16};
            FMT_J:   word = {op, imm26};
            default: word = SYSCALL_WORD;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/istr_fifo.sv
// Small synchronous FIFO holding encoded words; head is the registered oldest entry.
// clr_i empties it in one cycle without touching the storage array.
module istr_fifo
    import istr_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full_o  = (cnt_q == CNT_FULL);
        empty_o = (cnt_q == '0);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        head_o  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/istr_encoder.sv
// Encodes instruction field tuples into 32-bit words and writes a burst of them to memory.
// Define ISTR_NOP_PAD_EN to let a pad pulse finish the burst with NOP words.
module istr_encoder
    import istr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [CNT_W-1:0]   len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         fmt,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNC_W-1:0]  func,
    input  logic [REG_W-1:0]   rs,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rd,
    input  logic [REG_W-1:0]   shamt,
    input  logic [IMM16_W-1:0] imm16,
    input  logic [IMM26_W-1:0] imm26,
    input  logic               pad,
    output logic               mem_req,
    input  logic               mem_ack,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_wdata,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   wr_count
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;

    logic               run;
    logic               padding;
    logic               req;
    logic               wr_fire;
    logic               last_word;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_clr;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WORD_W-1:0]  fifo_head;
    logic [WORD_W-1:0]  enc_word;

`ifdef ISTR_NOP_PAD_EN
    logic pad_q, pad_d;

    always_comb begin
        pad_d = pad_q;
        if (state_q == ST_RUN && pad) begin
            pad_d = 1'b1;
        end
        if (state_d != ST_RUN) begin
            pad_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_q <= 1'b0;
        end else begin
            pad_q <= pad_d;
        end
    end

    assign padding = pad_q;
`else
    logic pad_unused;

    assign pad_unused = pad;
    assign padding    = 1'b0;
`endif

    assign enc_word = encode(fmt, op, rs, rt, rd, shamt, func, imm16, imm26);

    // Outputs are masked by rst so they read reset values during the reset cycle itself.
    always_comb begin
        run       = (state_q == ST_RUN) && !rst;
        req       = run && (!fifo_empty || padding);
        wr_fire   = req && mem_ack;
        fifo_pop  = wr_fire && !fifo_empty;
        in_ready  = run && !fifo_full && !padding;
        fifo_push = in_valid && in_ready;
        last_word = ((cnt_q + 11'd1) == len_q);

        mem_req   = req;
        mem_wdata = '0;
        if (req) begin
            mem_wdata = fifo_empty ? NOP_WORD : fifo_head;
        end
        mem_addr  = rst ? '0 : addr_q;
        wr_count  = rst ? '0 : cnt_q;
        busy      = run;
        done      = (state_q == ST_DONE) && !rst;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        fifo_clr = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_d  = base_addr;
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (wr_fire) begin
                    addr_d = addr_q + 10'd1;
                    cnt_d  = cnt_q + 11'd1;
                    if (last_word) begin
                        state_d  = ST_DONE;
                        fifo_clr = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    istr_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (fifo_clr),
        .push_i  (fifo_push),
        .wdata_i (enc_word),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_istr_encoder.sv
// Scoreboard bench for istr_encoder: expected writes are queued on acceptance and checked on mem_ack.
module tb_istr_encoder;

    typedef struct packed {
        logic [1:0]  f;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] i16;
        logic [25:0] i26;
    } tup_t;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = '0;
    logic [5:0]  op = '0;
    logic [5:0]  func = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  shamt = '0;
    logic [15:0] imm16 = '0;
    logic [25:0] imm26 = '0;
    logic        pad = 1'b0;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [10:0] wr_count;

    int   total = 0;
    int   bad = 0;
    wr_t  sb[$];
    wr_t  exp_w;
    logic [9:0] exp_addr = '0;

    always #5 clk = ~clk;

    istr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .op        (op),
        .func      (func),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .imm16     (imm16),
        .imm26     (imm26),
        .pad       (pad),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count)
    );

    // Each write handshake that will complete at the next rising edge is checked here.
    always @(negedge clk) begin
        if (!rst && mem_req === 1'b1 && mem_ack === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected got %h@%h want none", mem_wdata, mem_addr);
            end else begin
                exp_w = sb.pop_front();
                if (mem_addr !== exp_w.addr || mem_wdata !== exp_w.data) begin
                    bad++;
                    $display("FAIL write_data got %h@%h want %h@%h",
                             mem_wdata, mem_addr, exp_w.data, exp_w.addr);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_word(input tup_t t);
        logic [31:0] w;
        case (t.f)
            2'd0:    w = {t.op, t.rs, t.rt, t.rd, t.shamt, t.func};
            2'd1:    w = {t.op, t.rs, t.rt, t.i16};
            2'd2:    w = {t.op, t.i26};
            default: w = 32'h0000000C;
        endcase
        return w;
    endfunction

    function automatic tup_t rnd_tup(input logic [1:0] f);
        tup_t t;
        t       = tup_t'({$urandom, $urandom, $urandom, $urandom});
        t.f     = f;
        return t;
    endfunction

    task automatic apply_tup(input tup_t t);
        fmt = t.f; op = t.op; func = t.func; rs = t.rs; rt = t.rt;
        rd = t.rd; shamt = t.shamt; imm16 = t.i16; imm26 = t.i26;
    endtask

    task automatic do_start(input logic [9:0] b, input logic [10:0] l);
        base_addr = b;
        len = l;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = b;
    endtask

    task automatic send(input tup_t t, input logic [31:0] want);
        bit got;
        got = 1'b0;
        apply_tup(t);
        in_valid = 1'b1;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sb.push_back({exp_addr, want});
                exp_addr = exp_addr + 10'd1;
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL send_timeout got in_ready=0 want 1");
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (done !== 1'b1) begin
            total++; bad++;
            $display("FAIL done_timeout got done=%b want 1", done);
        end
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({in_ready, mem_req, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got %b want 0000", {in_ready, mem_req, busy, done});
        end
        total++;
        if (mem_addr !== 10'h000 || mem_wdata !== 32'h0 || wr_count !== 11'd0) begin
            bad++;
            $display("FAIL reset_values got %h %h %0d want 0 0 0", mem_addr, mem_wdata, wr_count);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        tup_t t;
        mem_ack = 1'b1;
        do_start(10'h010, 11'd3);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy got busy=%b done=%b want 1 0", busy, done);
        end
        t = '0; t.f = 2'd0; t.rs = 5'd1; t.rt = 5'd2; t.rd = 5'd3; t.func = 6'h20;
        t.i16 = 16'hABCD; t.i26 = 26'h155;
        send(t, 32'h00221820);
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_wdata !== 32'h00221820) begin
            bad++;
            $display("FAIL basic_latency got req=%b data=%h want 1 00221820", mem_req, mem_wdata);
        end
        @(posedge clk); #1;
        t = '0; t.f = 2'd1; t.op = 6'h08; t.rs = 5'd1; t.rt = 5'd2; t.i16 = 16'hFFFF;
        t.rd = 5'd7; t.func = 6'h3F;
        send(t, 32'h2022FFFF);
        t = '0; t.f = 2'd2; t.op = 6'd2; t.i26 = 26'h0000100; t.rs = 5'd9;
        send(t, 32'h08000100);
        wait_done(30);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_count !== 11'd3) begin
            bad++;
            $display("FAIL basic_done got done=%b busy=%b cnt=%0d want 1 0 3", done, busy, wr_count);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL basic_drain got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        tup_t tl[6];
        int   acc;
        bit   stable;
        for (int i = 0; i < 6; i++) tl[i] = rnd_tup(2'(i % 3));
        mem_ack = 1'b0;
        do_start(10'h080, 11'd6);
        acc = 0;
        stable = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (acc < 6) begin
                apply_tup(tl[acc]);
                in_valid = 1'b1;
            end
            @(negedge clk);
            if (c >= 1 && (mem_req !== 1'b1 || mem_addr !== 10'h080 ||
                           mem_wdata !== ref_word(tl[0]))) stable = 1'b0;
            if (in_valid && in_ready === 1'b1) begin
                sb.push_back({exp_addr, ref_word(tl[acc])});
                exp_addr = exp_addr + 10'd1;
                acc++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (acc != 4 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_full got acc=%0d ready=%b want 4 0", acc, in_ready);
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_stable got unstable req/addr/data want stable");
        end
        mem_ack = 1'b1;
        for (int c = 0; c < 40 && acc < 6; c++) begin
            apply_tup(tl[acc]);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sb.push_back({exp_addr, ref_word(tl[acc])});
                exp_addr = exp_addr + 10'd1;
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_done(40);
        total++;
        if (wr_count !== 11'd6 || sb.size() != 0) begin
            bad++;
            $display("FAIL bp_total got cnt=%0d pending=%0d want 6 0", wr_count, sb.size());
        end
    endtask

    task automatic test_wrap();
        mem_ack = 1'b1;
        do_start(10'h3FF, 11'd2);
        send(rnd_tup(2'd3), 32'h0000000C);
        send(rnd_tup(2'd3), 32'h0000000C);
        wait_done(30);
        total++;
        if (wr_count !== 11'd2 || sb.size() != 0 || mem_addr !== 10'h001) begin
            bad++;
            $display("FAIL wrap_end got cnt=%0d pending=%0d addr=%h want 2 0 001",
                     wr_count, sb.size(), mem_addr);
        end
    endtask

    task automatic test_len0_and_restart();
        tup_t t;
        mem_ack = 1'b1;
        do_start(10'h050, 11'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL len0 got done=%b busy=%b req=%b rdy=%b want 1 0 0 0",
                     done, busy, mem_req, in_ready);
        end
        do_start(10'h100, 11'd2);
        t = rnd_tup(2'd1);
        send(t, ref_word(t));
        base_addr = 10'h200;
        len = 11'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = rnd_tup(2'd0);
        send(t, ref_word(t));
        wait_done(30);
        total++;
        if (wr_count !== 11'd2 || sb.size() != 0) begin
            bad++;
            $display("FAIL restart_ignored got cnt=%0d pending=%0d want 2 0", wr_count, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        tup_t t;
        mem_ack = 1'b0;
        do_start(10'h020, 11'd4);
        t = rnd_tup(2'd2);
        send(t, ref_word(t));
        t = rnd_tup(2'd1);
        send(t, ref_word(t));
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pending got req=%b want 1", mem_req);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({in_ready, mem_req, busy, done} !== 4'b0000 || mem_addr !== 10'h0 ||
            mem_wdata !== 32'h0 || wr_count !== 11'd0) begin
            bad++;
            $display("FAIL rstmid_outputs got %b %h %h %0d want 0000 0 0 0",
                     {in_ready, mem_req, busy, done}, mem_addr, mem_wdata, wr_count);
        end
        rst = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        total++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_idle got req=%b busy=%b want 0 0", mem_req, busy);
        end
        mem_ack = 1'b1;
        do_start(10'h030, 11'd2);
        t = rnd_tup(2'd0);
        send(t, ref_word(t));
        t = rnd_tup(2'd3);
        send(t, ref_word(t));
        wait_done(30);
        total++;
        if (wr_count !== 11'd2 || sb.size() != 0) begin
            bad++;
            $display("FAIL rstmid_fresh got cnt=%0d pending=%0d want 2 0", wr_count, sb.size());
        end
    endtask

    task automatic test_pad();
        tup_t t;
        mem_ack = 1'b1;
        do_start(10'h040, 11'd5);
        t = rnd_tup(2'd1);
        send(t, ref_word(t));
        t = rnd_tup(2'd2);
        send(t, ref_word(t));
        pad = 1'b1;
        @(posedge clk); #1;
        pad = 1'b0;
`ifdef ISTR_NOP_PAD_EN
        for (int i = 0; i < 3; i++) begin
            sb.push_back({exp_addr, 32'h00000000});
            exp_addr = exp_addr + 10'd1;
        end
        wait_done(60);
        total++;
        if (wr_count !== 11'd5 || sb.size() != 0) begin
            bad++;
            $display("FAIL pad_fill got cnt=%0d pending=%0d want 5 0", wr_count, sb.size());
        end
`else
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || wr_count !== 11'd2 || sb.size() != 0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL pad_ignored got busy=%b cnt=%0d pending=%0d rdy=%b want 1 2 0 1",
                     busy, wr_count, sb.size(), in_ready);
        end
`endif
        hard_reset();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_len0_and_restart();
        test_reset_mid();
        test_pad();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
